// File: rtl/apb_delayer_ratio.sv
// APB bridge that stretches each transfer to (device cycles x R_NUM / 2^FRAC_BITS).
// Define APB_DELAYER_RATIO_BYPASS_EN to add a per-transfer bypass input.
module apb_delayer_ratio #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int R_NUM     = 10,
  parameter int FRAC_BITS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
`ifdef APB_DELAYER_RATIO_BYPASS_EN
  input  logic                bypass,
`endif
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  localparam int PW = CNT_W + $clog2(R_NUM + 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] C_ONE = 1;
  localparam logic [PW:0]      P_ONE = 1;
  localparam logic [PW:0]      P_LIM = (PW+1)'(CMAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  nf;
  logic [CNT_W-1:0]  wnext;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              hs;
  logic              fwd;
  logic              byp;
  logic [PW:0]       nf_x;
  logic [PW:0]       prod;
  logic [PW:0]       dly;

`ifdef APB_DELAYER_RATIO_BYPASS_EN
  logic byp_q;

  // Latched at setup so a mid-transfer toggle cannot change the mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_q <= 1'b0;
    end else if (state == IDLE && in_psel) begin
      byp_q <= bypass;
    end
  end

  assign byp = byp_q;
`else
  assign byp = 1'b0;
`endif

  assign hs = (state == ACCESS) & in_psel & in_penable & out_pready;

  always_comb begin
    nf    = (n == CMAX) ? n : n + C_ONE;
    nf_x  = (PW+1)'(nf);
    prod  = (nf_x * (PW+1)'(R_NUM)) >> FRAC_BITS;
    dly   = (prod > nf_x + P_ONE) ? prod : nf_x + P_ONE;
    if (dly > P_LIM) dly = P_LIM;
    wnext = '0;
    if (dly >= nf_x + P_ONE) wnext = CNT_W'(dly - nf_x - P_ONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      wcnt     <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_psel) begin
            state <= ACCESS;
            n     <= C_ONE;
          end
        end
        ACCESS: begin
          if (!in_psel) begin
            state <= IDLE;
            n     <= '0;
          end else if (hs && byp) begin
            state <= IDLE;
            n     <= '0;
          end else if (hs) begin
            n        <= nf;
            rdata_q  <= out_prdata;
            slverr_q <= out_pslverr;
            wcnt     <= wnext;
            state    <= (wnext != '0) ? WAIT : RESP;
          end else begin
            n <= nf;
          end
        end
        WAIT: begin
          wcnt <= wcnt - C_ONE;
          if (wcnt <= C_ONE) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          n     <= '0;
        end
      endcase
    end
  end

  assign fwd = (state == IDLE) | (state == ACCESS);

  always_comb begin
    out_paddr   = fwd ? in_paddr   : '0;
    out_psel    = fwd & in_psel;
    out_penable = fwd & in_penable;
    out_pprot   = fwd ? in_pprot   : '0;
    out_pwrite  = fwd & in_pwrite;
    out_pwdata  = fwd ? in_pwdata  : '0;
    out_pstrb   = fwd ? in_pstrb   : '0;
    in_pready   = 1'b0;
    in_prdata   = '0;
    in_pslverr  = 1'b0;
    if (state == RESP) begin
      in_pready  = 1'b1;
      in_prdata  = rdata_q;
      in_pslverr = slverr_q;
    end else if (byp && state == ACCESS) begin
      in_pready  = out_pready;
      in_prdata  = out_prdata;
      in_pslverr = out_pslverr;
    end
  end

endmodule

// File: tb/tb_apb_delayer_ratio.sv
// Directed bench for apb_delayer_ratio at ratios 5, 1 and 1.5.
// Bypass scenarios are included when APB_DELAYER_RATIO_BYPASS_EN is defined.
module tb_apb_delayer_ratio;

  logic        clock;
  logic        reset;
  logic [1:0]  cur;
  logic        psel;
  logic [2:0]  psel_v;
  logic        penable;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        s_pready;
  logic [31:0] s_prdata;
  logic        s_pslverr;
`ifdef APB_DELAYER_RATIO_BYPASS_EN
  logic        bypass;
`endif

  logic        ipr  [3];
  logic [31:0] iprd [3];
  logic        ierr [3];
  logic [31:0] o_paddr [3];
  logic        o_psel [3];
  logic        o_pen  [3];
  logic [2:0]  o_pprot [3];
  logic        o_pwr  [3];
  logic [31:0] o_pwd  [3];
  logic [3:0]  o_pstrb [3];

  int n_chk;
  int n_fail;

  assign psel_v = psel ? 3'(3'b001 << cur) : 3'b000;

  apb_delayer_ratio #(.R_NUM(10), .FRAC_BITS(1)) u_r5 (
    .clock(clock), .reset(reset),
`ifdef APB_DELAYER_RATIO_BYPASS_EN
    .bypass(bypass),
`endif
    .in_paddr(paddr), .in_psel(psel_v[0]), .in_penable(penable),
    .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata),
    .in_pstrb(pstrb), .in_pready(ipr[0]), .in_prdata(iprd[0]),
    .in_pslverr(ierr[0]), .out_paddr(o_paddr[0]), .out_psel(o_psel[0]),
    .out_penable(o_pen[0]), .out_pprot(o_pprot[0]), .out_pwrite(o_pwr[0]),
    .out_pwdata(o_pwd[0]), .out_pstrb(o_pstrb[0]), .out_pready(s_pready),
    .out_prdata(s_prdata), .out_pslverr(s_pslverr)
  );

  apb_delayer_ratio #(.R_NUM(2), .FRAC_BITS(1)) u_r1 (
    .clock(clock), .reset(reset),
`ifdef APB_DELAYER_RATIO_BYPASS_EN
    .bypass(bypass),
`endif
    .in_paddr(paddr), .in_psel(psel_v[1]), .in_penable(penable),
    .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata),
    .in_pstrb(pstrb), .in_pready(ipr[1]), .in_prdata(iprd[1]),
    .in_pslverr(ierr[1]), .out_paddr(o_paddr[1]), .out_psel(o_psel[1]),
    .out_penable(o_pen[1]), .out_pprot(o_pprot[1]), .out_pwrite(o_pwr[1]),
    .out_pwdata(o_pwd[1]), .out_pstrb(o_pstrb[1]), .out_pready(s_pready),
    .out_prdata(s_prdata), .out_pslverr(s_pslverr)
  );

  apb_delayer_ratio #(.R_NUM(3), .FRAC_BITS(1)) u_r15 (
    .clock(clock), .reset(reset),
`ifdef APB_DELAYER_RATIO_BYPASS_EN
    .bypass(bypass),
`endif
    .in_paddr(paddr), .in_psel(psel_v[2]), .in_penable(penable),
    .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata),
    .in_pstrb(pstrb), .in_pready(ipr[2]), .in_prdata(iprd[2]),
    .in_pslverr(ierr[2]), .out_paddr(o_paddr[2]), .out_psel(o_psel[2]),
    .out_penable(o_pen[2]), .out_pprot(o_pprot[2]), .out_pwrite(o_pwr[2]),
    .out_pwdata(o_pwd[2]), .out_pstrb(o_pstrb[2]), .out_pready(s_pready),
    .out_prdata(s_prdata), .out_pslverr(s_pslverr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one transfer on instance idx; the slave answers after `waits`
  // wait states. Returns the master-side latency (-1 on timeout).
  task automatic run_xfer(
    input  int          idx,
    input  logic        wr,
    input  int          waits,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdat,
    input  logic        err,
    input  bit          tog,
    output int          lat,
    output logic [31:0] got_rd,
    output logic        got_err,
    output int          leak,
    output bit          fwd_ok
  );
    bit hs;
    lat = -1; leak = 0; hs = 0;
    got_rd = '0; got_err = 1'b0; fwd_ok = 0;
    cur = 2'(idx);
    paddr = addr; pwrite = wr; pwdata = wdata;
    pstrb = 4'hF; pprot = 3'b010;
    psel = 1'b1; penable = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc >= 2) penable = 1'b1;
`ifdef APB_DELAYER_RATIO_BYPASS_EN
      if (tog && cyc == 2) bypass = ~bypass;
`endif
      s_pready  = (cyc == waits + 2);
      s_prdata  = s_pready ? rdat : 32'h0;
      s_pslverr = s_pready & err;
      #2;
      if (cyc == 2)
        fwd_ok = o_psel[idx] && o_pen[idx] && o_paddr[idx] == addr &&
                 o_pwr[idx] == wr && o_pwd[idx] == wdata &&
                 o_pstrb[idx] == 4'hF && o_pprot[idx] == 3'b010;
      if (hs && o_psel[idx]) leak++;
      if (ipr[idx]) begin
        lat = cyc; got_rd = iprd[idx]; got_err = ierr[idx];
      end
      if (s_pready) hs = 1;
      tick();
      if (lat > 0) break;
    end
    psel = 1'b0; penable = 1'b0;
    s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    #1;
    if (ipr[0] !== 1'b0) begin
      $display("FAIL reset_pready got=%b exp=0", ipr[0]); n_fail++;
    end
    n_chk++;
    if (iprd[0] !== 32'h0 || ierr[0] !== 1'b0) begin
      $display("FAIL reset_rdata got=%h/%b exp=0/0", iprd[0], ierr[0]);
      n_fail++;
    end
    n_chk++;
    cur = 0; paddr = 32'h1234; psel = 1'b1;
    #1;
    if (o_psel[0] !== 1'b1 || o_paddr[0] !== 32'h1234) begin
      $display("FAIL reset_fwd got=%b/%h exp=1/00001234",
               o_psel[0], o_paddr[0]);
      n_fail++;
    end
    n_chk++;
    psel = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_r5();
    int lat, leak; logic [31:0] rd; logic er; bit fo;
    run_xfer(0, 1'b0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 10) begin
      $display("FAIL read_r5_lat got=%0d exp=10", lat); n_fail++;
    end
    n_chk++;
    if (rd !== 32'hDEADBEEF) begin
      $display("FAIL read_r5_rdata got=%h exp=deadbeef", rd); n_fail++;
    end
    n_chk++;
    if (leak !== 0) begin
      $display("FAIL read_r5_psel_hold got=%0d exp=0", leak); n_fail++;
    end
    n_chk++;
    if (!fo) begin
      $display("FAIL read_r5_fwd got=0 exp=1"); n_fail++;
    end
    n_chk++;
    #1;
    if (ipr[0] !== 1'b0) begin
      $display("FAIL read_r5_resp1 got=%b exp=0", ipr[0]); n_fail++;
    end
    n_chk++;
    tick();
  endtask

  task automatic test_write_r5();
    int lat, leak; logic [31:0] rd; logic er; bit fo;
    run_xfer(0, 1'b1, 3, 32'h88, 32'hA5A55A5A, 32'h0, 1'b1, 0,
             lat, rd, er, leak, fo);
    if (lat !== 25) begin
      $display("FAIL write_r5_lat got=%0d exp=25", lat); n_fail++;
    end
    n_chk++;
    if (er !== 1'b1) begin
      $display("FAIL write_r5_slverr got=%b exp=1", er); n_fail++;
    end
    n_chk++;
    if (!fo) begin
      $display("FAIL write_r5_fwd got=0 exp=1"); n_fail++;
    end
    n_chk++;
    tick();
  endtask

  task automatic test_ratio_low();
    int lat, leak; logic [31:0] rd; logic er; bit fo;
    run_xfer(1, 1'b0, 0, 32'h10, 32'h0, 32'h11223344, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 3) begin
      $display("FAIL ratio1_lat got=%0d exp=3", lat); n_fail++;
    end
    n_chk++;
    if (rd !== 32'h11223344) begin
      $display("FAIL ratio1_rdata got=%h exp=11223344", rd); n_fail++;
    end
    n_chk++;
    tick();
    run_xfer(2, 1'b0, 1, 32'h14, 32'h0, 32'h0BADF00D, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 4) begin
      $display("FAIL ratio15_lat got=%0d exp=4", lat); n_fail++;
    end
    n_chk++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, leak; logic [31:0] rd; logic er; bit fo;
    run_xfer(0, 1'b0, 0, 32'h20, 32'h0, 32'h00000001, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 10) begin
      $display("FAIL b2b_first_lat got=%0d exp=10", lat); n_fail++;
    end
    n_chk++;
    run_xfer(0, 1'b0, 1, 32'h24, 32'h0, 32'h00000002, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 15) begin
      $display("FAIL b2b_second_lat got=%0d exp=15", lat); n_fail++;
    end
    n_chk++;
    if (rd !== 32'h00000002) begin
      $display("FAIL b2b_second_rdata got=%h exp=00000002", rd); n_fail++;
    end
    n_chk++;
    tick();
  endtask

  task automatic test_protocol_error();
    int lat, leak, spur; logic [31:0] rd; logic er; bit fo;
    cur = 0; paddr = 32'h30; pwrite = 1'b0;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    spur = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (ipr[0]) spur++;
      tick();
    end
    if (spur !== 0) begin
      $display("FAIL proto_err_resp got=%0d exp=0", spur); n_fail++;
    end
    n_chk++;
    run_xfer(0, 1'b0, 0, 32'h34, 32'h0, 32'h5555AAAA, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 10) begin
      $display("FAIL proto_err_next_lat got=%0d exp=10", lat); n_fail++;
    end
    n_chk++;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int lat, leak, spur; logic [31:0] rd; logic er; bit fo;
    cur = 0; paddr = 32'h50; pwrite = 1'b0;
    psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1; s_pready = 1'b1; s_prdata = 32'hCAFEF00D;
    tick();
    s_pready = 1'b0; s_prdata = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    if (ipr[0] !== 1'b0) begin
      $display("FAIL rst_wait_pready got=%b exp=0", ipr[0]); n_fail++;
    end
    n_chk++;
    psel = 1'b1;
    #1;
    if (o_psel[0] !== 1'b1) begin
      $display("FAIL rst_wait_fwd got=%b exp=1", o_psel[0]); n_fail++;
    end
    n_chk++;
    psel = 1'b0;
    tick();
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (ipr[0]) spur++;
      tick();
    end
    if (spur !== 0) begin
      $display("FAIL rst_wait_spurious got=%0d exp=0", spur); n_fail++;
    end
    n_chk++;
    run_xfer(0, 1'b0, 0, 32'h54, 32'h0, 32'h12345678, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 10) begin
      $display("FAIL rst_wait_next_lat got=%0d exp=10", lat); n_fail++;
    end
    n_chk++;
    tick();
  endtask

`ifdef APB_DELAYER_RATIO_BYPASS_EN
  task automatic test_bypass();
    int lat, leak; logic [31:0] rd; logic er; bit fo;
    bypass = 1'b1;
    run_xfer(0, 1'b0, 2, 32'h60, 32'h0, 32'hFEEDFACE, 1'b0, 0,
             lat, rd, er, leak, fo);
    if (lat !== 4) begin
      $display("FAIL bypass_lat got=%0d exp=4", lat); n_fail++;
    end
    n_chk++;
    if (rd !== 32'hFEEDFACE) begin
      $display("FAIL bypass_rdata got=%h exp=feedface", rd); n_fail++;
    end
    n_chk++;
    tick();
    bypass = 1'b1;
    run_xfer(0, 1'b0, 2, 32'h64, 32'h0, 32'h1, 1'b0, 1,
             lat, rd, er, leak, fo);
    if (lat !== 4) begin
      $display("FAIL bypass_tog_off_lat got=%0d exp=4", lat); n_fail++;
    end
    n_chk++;
    tick();
    bypass = 1'b0;
    run_xfer(0, 1'b0, 0, 32'h68, 32'h0, 32'h2, 1'b0, 1,
             lat, rd, er, leak, fo);
    if (lat !== 10) begin
      $display("FAIL bypass_tog_on_lat got=%0d exp=10", lat); n_fail++;
    end
    n_chk++;
    bypass = 1'b0;
    tick();
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; cur = 0; psel = 1'b0; penable = 1'b0;
    paddr = '0; pprot = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
    s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
`ifdef APB_DELAYER_RATIO_BYPASS_EN
    bypass = 1'b0;
`endif
    test_reset();
    test_read_r5();
    test_write_r5();
    test_ratio_low();
    test_back_to_back();
    test_protocol_error();
    test_reset_in_wait();
`ifdef APB_DELAYER_RATIO_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_delayer_ratio.md
Name: apb_delayer_ratio

Overview:
- Parametrised APB latency-scaling bridge between an APB master (in_*) and a single APB slave (out_*).
- Stretches every transfer so the master sees a total latency of (device cycles × ratio), where the ratio is a fixed-point value R_NUM / 2^FRAC_BITS.
- Models a slow device clock on a fast core clock, generalising the fixed ×(r·s) delayer: configurable address/data widths, fractional ratio, saturating counters, a guaranteed minimum one-cycle wait, and an optional bypass.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- R_NUM, 10, ratio numerator in fixed point; ratio = R_NUM / 2^FRAC_BITS; must be ≥ 2^FRAC_BITS.
- FRAC_BITS, 1, number of fractional bits of the ratio.
- CNT_W, 16, width of the cycle counter n; the product register is CNT_W + $clog2(R_NUM+1) bits.

Ports:
- clock, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- in_paddr / in_psel / in_penable / in_pprot / in_pwrite / in_pwdata / in_pstrb, input, ADDR_W / 1 / 1 / 3 / 1 / DATA_W / DATA_W/8, master request.
- in_pready / in_prdata / in_pslverr, output, 1 / DATA_W / 1, response to master.
- out_paddr / out_psel / out_penable / out_pprot / out_pwrite / out_pwdata / out_pstrb, output, same widths as in_*, request to slave.
- out_pready / out_prdata / out_pslverr, input, 1 / DATA_W / 1, slave response.

Behaviour:
- States:
  - IDLE(0), ACCESS(1), WAIT(2), RESP(3).
  - reset → IDLE; n = 0, wcnt = 0, captured rdata/slverr = 0.
  - Reset mid-transfer aborts the transfer with no response to the master.
- Forwarding:
  - In IDLE and ACCESS, all out_* = in_* combinationally.
  - In WAIT and RESP, all out_* = 0 (psel/penable low, address/data/strb/prot zero).
- in_pready / in_prdata / in_pslverr:
  - Driven only in RESP: pready = 1, prdata and pslverr = captured values.
  - All other states: 0. Reset value 0.
- Transitions:
  - IDLE → ACCESS when in_psel = 1; n ← 1 (setup cycle is cycle 1).
  - In ACCESS, each cycle n ← sat(n + 1) (saturating at 2^CNT_W − 1).
  - Handshake = ACCESS & in_psel & in_penable & out_pready. On the handshake cycle:
    - nf = sat(n + 1), the count including the handshake cycle.
    - Capture out_prdata and out_pslverr.
    - D = max(nf + 1, (nf · R_NUM) >> FRAC_BITS), using truncating shift.
    - wcnt ← D − nf − 1.
    - Next state: WAIT if wcnt > 0, else RESP.
  - WAIT: wcnt decrements each cycle; when wcnt == 1 and decrementing, → RESP.
  - RESP: exactly one cycle; → IDLE, n ← 0.
- Latency: in_pready is asserted in cycle D counted from the first in_psel cycle. With ratio ≥ 1 it is always ≥ 1 cycle after the slave handshake, so the master never sees pready in the slave handshake cycle.
- Arithmetic: the product is computed at full width (no overflow). D is clamped to 2^CNT_W − 1 before subtraction; if the clamped D < nf + 1, then wcnt = 0.
- Protocol error: in_psel dropping in ACCESS before the handshake → IDLE with no response, n ← 0.
- Back-to-back: the next setup is accepted in IDLE on the cycle after RESP; no extra bubble is added.

Optional Feature:
- Macro: APB_DELAYER_RATIO_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - bypass is sampled only in IDLE when in_psel rises, and latched for the whole transfer; a mid-transfer change is ignored.
  - With bypass latched high: in_pready/in_prdata/in_pslverr = out_pready/out_prdata/out_pslverr combinationally in ACCESS, there is no WAIT/RESP, and the handshake returns to IDLE.
- When undefined: no bypass port; always delays.

Test Plan:
- Read, R_NUM=10, FRAC_BITS=1, slave pready in first access cycle (nf=2) → D=10: WAIT 7 cycles, in_pready=1 only in cycle 10; in_prdata = slave value 0xDEADBEEF; out_psel=0 in cycles 3–10.
- Write with 3 slave wait states (nf=5), ratio 5 → in_pready in cycle 25; pslverr=1 from the slave is returned in cycle 25.
- Ratio 1 (R_NUM=2, FRAC_BITS=1), nf=2 → D=3: no WAIT, RESP in cycle 3. Ratio 1.5 (R_NUM=3), nf=3 → D=max(4,4)=4.
- Two back-to-back transfers → second setup in the cycle after RESP; each is delayed independently; n resets between transfers.
- Reset asserted during WAIT → next cycle IDLE, in_pready=0, out_psel follows in_psel; the following transfer has normal latency.
- APB_DELAYER_RATIO_BYPASS_EN with bypass=1 → in_pready coincides with out_pready (latency nf). Toggling bypass mid-transfer has no effect on the current transfer.
